// File: rtl/processor_debugger_pkg.sv
// Shared definitions for the processor debugger: command letters, parser
// error codes, parser state encoding and small command-classification helpers.
package processor_debugger_pkg;

   // Command letters, shared with the main controller
   localparam logic [7:0] CMDCODE_ID = 8'h49;   // 'I'
   localparam logic [7:0] CMDCODE_AC = 8'h41;   // 'A'
   localparam logic [7:0] CMDCODE_NP = 8'h4E;   // 'N'
   localparam logic [7:0] CMDCODE_RR = 8'h52;   // 'R' target only
   localparam logic [7:0] CMDCODE_RW = 8'h57;   // 'W' target then data
   localparam logic [7:0] CMDCODE_SE = 8'h53;   // 'S'
   localparam logic [7:0] CMDCODE_BE = 8'h42;   // 'B'
   localparam logic [7:0] CMDCODE_SB = 8'h50;   // 'P' data only

   // Framing characters
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   // Error reason codes
   localparam logic [2:0] ERR_NONE        = 3'd0;
   localparam logic [2:0] ERR_UNKNOWN_CMD = 3'd1;
   localparam logic [2:0] ERR_SYNTAX      = 3'd2;
   localparam logic [2:0] ERR_OVERFLOW    = 3'd3;
   localparam logic [2:0] ERR_OVERRUN     = 3'd4;
   localparam logic [2:0] ERR_TIMEOUT     = 3'd5;

   // Maximum hex digits per argument field
   localparam logic [1:0] TGT_MAX_DIGITS = 2'd2;
   localparam logic [3:0] DAT_MAX_DIGITS = 4'd8;

   // Parser state encoding
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEP     = 3'd1,
      ST_TGT     = 3'd2,
      ST_DAT     = 3'd3,
      ST_EOL     = 3'd4,
      ST_ISSUE   = 3'd5,
      ST_DISCARD = 3'd6
   } parser_state_e;

   // True for any letter the debugger understands
   function automatic logic is_known_cmd(input logic [7:0] c);
      return (c == CMDCODE_ID) || (c == CMDCODE_AC) || (c == CMDCODE_NP) ||
             (c == CMDCODE_RR) || (c == CMDCODE_RW) || (c == CMDCODE_SE) ||
             (c == CMDCODE_BE) || (c == CMDCODE_SB);
   endfunction

   // True for letters followed by at least one argument
   function automatic logic cmd_has_args(input logic [7:0] c);
      return (c == CMDCODE_RR) || (c == CMDCODE_RW) || (c == CMDCODE_SB);
   endfunction

   // True for letters whose first argument is a register target
   function automatic logic cmd_has_target(input logic [7:0] c);
      return (c == CMDCODE_RR) || (c == CMDCODE_RW);
   endfunction

endpackage

// File: rtl/processor_debugger_hex_decoder.sv
// Combinational ASCII hex digit to nibble converter with a valid flag.
module processor_debugger_hex_decoder (
   input  logic [7:0] ascii_i,
   output logic [3:0] nibble_o,
   output logic       valid_o
);

   // Map '0'-'9', 'A'-'F', 'a'-'f' onto their nibble; anything else is invalid
   always_comb begin
      nibble_o = 4'h0;
      valid_o  = 1'b0;
      if ((ascii_i >= 8'h30) && (ascii_i <= 8'h39)) begin
         nibble_o = ascii_i[3:0];
         valid_o  = 1'b1;
      end else if (((ascii_i >= 8'h41) && (ascii_i <= 8'h46)) ||
                   ((ascii_i >= 8'h61) && (ascii_i <= 8'h66))) begin
         nibble_o = ascii_i[3:0] + 4'd9;
         valid_o  = 1'b1;
      end
   end

endmodule

// File: rtl/processor_debugger_uart_command_parser.sv
// Line-framed debug command parser: turns UART bytes into validated commands
// presented over a req/busy handshake, or a one-cycle error pulse with reason.
module processor_debugger_uart_command_parser
   import processor_debugger_pkg::*;
#(
   parameter int                     P_TIMEOUT_W      = 24,
   parameter logic [P_TIMEOUT_W-1:0] P_TIMEOUT_CYCLES = 24'd1000000
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iRX_VALID,
   input  logic [7:0]  iRX_DATA,
   output logic        oCMD_REQ,
   input  logic        iCMD_BUSY,
   output logic [7:0]  oCMD_CODE,
   output logic [7:0]  oCMD_TARGET,
   output logic [31:0] oCMD_DATA,
   output logic        oERROR,
   output logic [2:0]  oERROR_CODE
);

   parser_state_e          state_q, state_d;
   logic [7:0]             code_q, code_d;
   logic [7:0]             target_q, target_d;
   logic [31:0]            data_q, data_d;
   logic [1:0]             tgt_cnt_q, tgt_cnt_d;
   logic [3:0]             dat_cnt_q, dat_cnt_d;
   logic [P_TIMEOUT_W-1:0] timer_q, timer_d;
   logic                   err_q, err_d;
   logic [2:0]             err_code_q, err_code_d;

   logic                   rx_is_hex;
   logic [3:0]             rx_nibble;
   logic                   byte_ev;
   logic                   is_lf;
   logic                   is_space;
   logic                   frame_active;
   logic [P_TIMEOUT_W-1:0] timer_inc;
   parser_state_e          err_state;

   processor_debugger_hex_decoder u_hex_decoder (
      .ascii_i  (iRX_DATA),
      .nibble_o (rx_nibble),
      .valid_o  (rx_is_hex)
   );

   // CR is invisible to the grammar; an error on LF already ends the line
   assign byte_ev      = iRX_VALID && (iRX_DATA != ASCII_CR);
   assign is_lf        = (iRX_DATA == ASCII_LF);
   assign is_space     = (iRX_DATA == ASCII_SPACE);
   assign frame_active = (state_q == ST_SEP) || (state_q == ST_TGT) ||
                         (state_q == ST_DAT) || (state_q == ST_EOL);
   assign timer_inc    = timer_q + 1'b1;
   assign err_state    = is_lf ? ST_IDLE : ST_DISCARD;

   // Next-state, field accumulation, timeout and error generation
   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      target_d   = target_q;
      data_d     = data_q;
      tgt_cnt_d  = tgt_cnt_q;
      dat_cnt_d  = dat_cnt_q;
      timer_d    = '0;
      err_d      = 1'b0;
      err_code_d = ERR_NONE;

      if (frame_active && !iRX_VALID && (P_TIMEOUT_CYCLES != '0)) begin
         if (timer_inc == P_TIMEOUT_CYCLES) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = ST_IDLE;
         end else begin
            timer_d = timer_inc;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (byte_ev && !is_lf && !is_space) begin
               if (is_known_cmd(iRX_DATA)) begin
                  code_d    = iRX_DATA;
                  target_d  = '0;
                  data_d    = '0;
                  tgt_cnt_d = '0;
                  dat_cnt_d = '0;
                  state_d   = cmd_has_args(iRX_DATA) ? ST_SEP : ST_EOL;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_UNKNOWN_CMD;
                  state_d    = err_state;
               end
            end
         end

         ST_SEP: begin
            if (byte_ev) begin
               if (is_space) begin
                  state_d = cmd_has_target(code_q) ? ST_TGT : ST_DAT;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_SYNTAX;
                  state_d    = err_state;
               end
            end
         end

         ST_TGT: begin
            if (byte_ev) begin
               if (rx_is_hex) begin
                  if (tgt_cnt_q == TGT_MAX_DIGITS) begin
                     err_d      = 1'b1;
                     err_code_d = ERR_OVERFLOW;
                     state_d    = err_state;
                  end else begin
                     target_d  = {target_q[3:0], rx_nibble};
                     tgt_cnt_d = tgt_cnt_q + 2'd1;
                  end
               end else if (is_space && (code_q == CMDCODE_RW) && (tgt_cnt_q != '0)) begin
                  state_d = ST_DAT;
               end else if (is_lf && (code_q == CMDCODE_RR) && (tgt_cnt_q != '0)) begin
                  state_d = ST_ISSUE;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_SYNTAX;
                  state_d    = err_state;
               end
            end
         end

         ST_DAT: begin
            if (byte_ev) begin
               if (rx_is_hex) begin
                  if (dat_cnt_q == DAT_MAX_DIGITS) begin
                     err_d      = 1'b1;
                     err_code_d = ERR_OVERFLOW;
                     state_d    = err_state;
                  end else begin
                     data_d    = {data_q[27:0], rx_nibble};
                     dat_cnt_d = dat_cnt_q + 4'd1;
                  end
               end else if (is_lf && (dat_cnt_q != '0)) begin
                  state_d = ST_ISSUE;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_SYNTAX;
                  state_d    = err_state;
               end
            end
         end

         ST_EOL: begin
            if (byte_ev) begin
               if (is_lf) begin
                  state_d = ST_ISSUE;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_SYNTAX;
                  state_d    = err_state;
               end
            end
         end

         ST_ISSUE: begin
            if (!iCMD_BUSY) begin
               state_d = ST_IDLE;
            end
            if (byte_ev) begin
               err_d      = 1'b1;
               err_code_d = ERR_OVERRUN;
            end
         end

         ST_DISCARD: begin
            if (byte_ev && is_lf) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state_q    <= ST_IDLE;
         code_q     <= '0;
         target_q   <= '0;
         data_q     <= '0;
         tgt_cnt_q  <= '0;
         dat_cnt_q  <= '0;
         timer_q    <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         target_q   <= target_d;
         data_q     <= data_d;
         tgt_cnt_q  <= tgt_cnt_d;
         dat_cnt_q  <= dat_cnt_d;
         timer_q    <= timer_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign oCMD_REQ    = (state_q == ST_ISSUE);
   assign oCMD_CODE   = code_q;
   assign oCMD_TARGET = target_q;
   assign oCMD_DATA   = data_q;
   assign oERROR      = err_q;
   assign oERROR_CODE = err_code_q;

endmodule

// File: tb/tb_processor_debugger_uart_command_parser.sv
// Testbench for the UART command parser: directed scenarios plus random lines
// checked against a line-level reference model through an event scoreboard.
module tb_processor_debugger_uart_command_parser;

   typedef logic [7:0] u8;
   typedef u8 byte_q_t[$];

   typedef struct {
      bit          is_err;
      logic [7:0]  code;
      logic [7:0]  target;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        cmd_req;
   logic        cmd_busy;
   logic [7:0]  cmd_code;
   logic [7:0]  cmd_target;
   logic [31:0] cmd_data;
   logic        err;
   logic [2:0]  err_code;

   exp_t exp_q[$];
   int   checks_total  = 0;
   int   checks_passed = 0;
   int   last_req_len  = 0;
   bit   busy_rand     = 1'b0;
   bit   busy_force    = 1'b0;

   always #5 clk = ~clk;

   processor_debugger_uart_command_parser #(
      .P_TIMEOUT_W      (24),
      .P_TIMEOUT_CYCLES (24'd16)
   ) dut (
      .iCLOCK      (clk),
      .inRESET     (rst_n),
      .iRX_VALID   (rx_valid),
      .iRX_DATA    (rx_data),
      .oCMD_REQ    (cmd_req),
      .iCMD_BUSY   (cmd_busy),
      .oCMD_CODE   (cmd_code),
      .oCMD_TARGET (cmd_target),
      .oCMD_DATA   (cmd_data),
      .oERROR      (err),
      .oERROR_CODE (err_code)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks_total++;
      if (act === req) checks_passed++;
      else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
   endtask

   function automatic byte_q_t s2q(input string s);
      byte_q_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(u8'(s[i]));
      return q;
   endfunction

   function automatic bit isHex(input u8 c);
      return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
   endfunction

   function automatic logic [3:0] hexVal(input u8 c);
      if (c <= 8'h39) return 4'(c - 8'h30);
      if (c <= 8'h46) return 4'(c - 8'h37);
      return 4'(c - 8'h57);
   endfunction

   function automatic void expectCmd(input u8 code, input u8 tgt, input logic [31:0] dat);
      exp_t e;
      e.is_err = 1'b0; e.code = code; e.target = tgt; e.data = dat;
      exp_q.push_back(e);
   endfunction

   function automatic void expectErr(input logic [2:0] code);
      exp_t e;
      e.is_err = 1'b1; e.code = {5'd0, code}; e.target = 8'h00; e.data = 32'h0;
      exp_q.push_back(e);
   endfunction

   // Reference model: the outcome of one complete line, judged as text
   function automatic void modelLine(input byte_q_t line);
      u8           c[$];
      int          p = 0;
      int          nargs;
      u8           letter;
      logic [31:0] val;
      logic [31:0] fields[2];
      bit          first_is_tgt;
      foreach (line[i]) if (line[i] != 8'h0D && line[i] != 8'h0A) c.push_back(line[i]);
      while (p < c.size() && c[p] == 8'h20) p++;
      if (p == c.size()) return;
      letter = c[p];
      p++;
      case (letter)
         8'h49, 8'h41, 8'h4E, 8'h53, 8'h42: nargs = 0;
         8'h52, 8'h50: nargs = 1;
         8'h57: nargs = 2;
         default: begin expectErr(3'd1); return; end
      endcase
      first_is_tgt = (letter == 8'h52) || (letter == 8'h57);
      fields[0] = 0;
      fields[1] = 0;
      for (int a = 0; a < nargs; a++) begin
         int maxd = (first_is_tgt && a == 0) ? 2 : 8;
         int n = 0;
         if (p >= c.size() || c[p] != 8'h20) begin expectErr(3'd2); return; end
         p++;
         val = 0;
         while (p < c.size() && isHex(c[p])) begin
            if (n == maxd) begin expectErr(3'd3); return; end
            val = (val << 4) | {28'd0, hexVal(c[p])};
            n++;
            p++;
         end
         if (n == 0) begin expectErr(3'd2); return; end
         fields[a] = val;
      end
      if (p < c.size()) begin expectErr(3'd2); return; end
      if (letter == 8'h57)      expectCmd(letter, fields[0][7:0], fields[1]);
      else if (letter == 8'h52) expectCmd(letter, fields[0][7:0], 32'h0);
      else if (letter == 8'h50) expectCmd(letter, 8'h00, fields[0]);
      else                      expectCmd(letter, 8'h00, 32'h0);
   endfunction

   // Random line: mostly well-formed commands with occasional corruption
   function automatic byte_q_t randomLine();
      string   letters = "IANSBRWPXZq7";
      string   hexchars = "0123456789abcdefABCDEF";
      byte_q_t q;
      u8       letter;
      int      nargs;
      letter = u8'(letters[$urandom_range(0, letters.len() - 1)]);
      if ($urandom_range(0, 4) == 0) q.push_back(8'h20);
      q.push_back(letter);
      case (letter)
         8'h52, 8'h50: nargs = 1;
         8'h57: nargs = 2;
         default: nargs = 0;
      endcase
      if ($urandom_range(0, 7) == 0) nargs = int'($urandom_range(0, 2));
      for (int a = 0; a < nargs; a++) begin
         int maxd = ((letter == 8'h52 || letter == 8'h57) && a == 0) ? 2 : 8;
         int r = int'($urandom_range(0, 9));
         int nd = (r == 0) ? 0 : (r == 1) ? maxd + 1 : int'($urandom_range(1, maxd));
         if ($urandom_range(0, 11) != 0) q.push_back(8'h20);
         for (int d = 0; d < nd; d++) q.push_back(u8'(hexchars[$urandom_range(0, 21)]));
      end
      if ($urandom_range(0, 9) == 0) q.push_back(8'h67);
      if ($urandom_range(0, 5) == 0) q.insert(int'($urandom_range(0, q.size())), 8'h0D);
      q.push_back(8'h0A);
      return q;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cmd_busy = busy_rand ? ($urandom_range(0, 1) == 1) : busy_force;
   endtask

   task automatic sendByte(input u8 b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic applyStimulus(input byte_q_t q, input int max_gap);
      foreach (q[i]) begin
         sendByte(q[i]);
         repeat ($urandom_range(0, max_gap)) tick();
      end
   endtask

   task automatic waitDrain(input int limit);
      int n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         checks_total++;
         $display("[TB] FAIL drain_timeout: %0d events pending, want 0", exp_q.size());
         exp_q.delete();
      end
      tick();
      tick();
   endtask

   // Monitor: pops the scoreboard whenever the DUT raises an error or transfers
   initial begin
      int          req_run = 0;
      bit          stable_ok = 1'b1;
      logic [7:0]  hold_code, hold_tgt;
      logic [31:0] hold_data;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            req_run = 0;
         end else begin
            if (err) begin
               if (exp_q.size() == 0) begin
                  checks_total++;
                  $display("[TB] FAIL unexpected_error: got code %0d, want no event", err_code);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("event_is_error", 32'd1, {31'd0, e.is_err});
                  if (e.is_err) checkOutput("error_code", {29'd0, err_code}, {24'd0, e.code});
               end
            end
            if (cmd_req) begin
               if (req_run == 0) begin
                  hold_code = cmd_code; hold_tgt = cmd_target; hold_data = cmd_data;
                  stable_ok = 1'b1;
               end else if (cmd_code !== hold_code || cmd_target !== hold_tgt || cmd_data !== hold_data) begin
                  stable_ok = 1'b0;
               end
               req_run++;
               if (!cmd_busy) begin
                  if (exp_q.size() == 0) begin
                     checks_total++;
                     $display("[TB] FAIL unexpected_command: got code 0x%0h, want no event", cmd_code);
                  end else begin
                     e = exp_q.pop_front();
                     checkOutput("event_is_error", 32'd0, {31'd0, e.is_err});
                     if (!e.is_err) begin
                        checkOutput("cmd_code", {24'd0, cmd_code}, {24'd0, e.code});
                        checkOutput("cmd_target", {24'd0, cmd_target}, {24'd0, e.target});
                        checkOutput("cmd_data", cmd_data, e.data);
                        checkOutput("cmd_stable", {31'd0, stable_ok}, 32'd1);
                     end
                  end
                  last_req_len = req_run;
                  req_run = 0;
               end
            end else begin
               req_run = 0;
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Main stimulus sequence
   initial begin
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      cmd_busy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_req", {31'd0, cmd_req}, 32'd0);
      checkOutput("reset_code", {24'd0, cmd_code}, 32'd0);
      checkOutput("reset_target", {24'd0, cmd_target}, 32'd0);
      checkOutput("reset_data", cmd_data, 32'd0);
      checkOutput("reset_error", {31'd0, err}, 32'd0);
      checkOutput("reset_error_code", {29'd0, err_code}, 32'd0);
      rst_n = 1'b1;
      tick();

      $display("[TB] read register command");
      expectCmd(8'h52, 8'h1F, 32'h0);
      applyStimulus(s2q("R 1F\n"), 0);
      waitDrain(50);
      checkOutput("r_req_cycles", last_req_len, 32'd1);

      $display("[TB] write command held by busy consumer");
      busy_force = 1'b1;
      expectCmd(8'h57, 8'h03, 32'hDEADBEEF);
      applyStimulus(s2q("W 03 deadBEEF\r\n"), 0);
      repeat (4) tick();
      busy_force = 1'b0;
      tick();
      waitDrain(50);
      checkOutput("w_req_cycles", last_req_len, 32'd6);

      $display("[TB] unknown command then recovery");
      expectErr(3'd1);
      expectCmd(8'h4E, 8'h00, 32'h0);
      applyStimulus(s2q("X\nN\n"), 0);
      waitDrain(50);

      $display("[TB] digit overflow and missing argument");
      expectErr(3'd3);
      expectErr(3'd2);
      applyStimulus(s2q("R 123\nP\n"), 0);
      waitDrain(50);
      checkOutput("req_after_errors", {31'd0, cmd_req}, 32'd0);

      $display("[TB] overrun while command pending");
      busy_force = 1'b1;
      expectErr(3'd4);
      expectCmd(8'h41, 8'h00, 32'h0);
      applyStimulus(s2q("A\n"), 0);
      sendByte(8'h49);
      tick();
      busy_force = 1'b0;
      tick();
      waitDrain(50);
      expectCmd(8'h42, 8'h00, 32'h0);
      applyStimulus(s2q("B\n"), 0);
      waitDrain(50);

      $display("[TB] inter-byte timeout");
      expectErr(3'd5);
      applyStimulus(s2q("W 1"), 0);
      repeat (16) tick();
      expectCmd(8'h53, 8'h00, 32'h0);
      applyStimulus(s2q("S\n"), 0);
      waitDrain(50);

      $display("[TB] reset mid-frame");
      applyStimulus(s2q("W 1"), 0);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_code", {24'd0, cmd_code}, 32'd0);
      checkOutput("midreset_req", {31'd0, cmd_req}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      expectCmd(8'h49, 8'h00, 32'h0);
      applyStimulus(s2q("I\n"), 0);
      waitDrain(50);

      $display("[TB] random lines");
      busy_rand = 1'b1;
      for (int n = 0; n < 60; n++) begin
         byte_q_t line = randomLine();
         modelLine(line);
         applyStimulus(line, 3);
         waitDrain(300);
      end
      busy_rand = 1'b0;
      tick();

      checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
